bidir_shift_stack: RTL and testbench
====================================

BIDIR_SHIFT_STACK -- requirements
Module: bidir_shift_stack

Interface
REQ-001 The module SHALL have parameter DEPTH, default 8, giving the number of entries (DEPTH >= 2).
REQ-002 The module SHALL have parameter WIDTH, default 8, giving the bits per entry.
REQ-003 The module SHALL have parameter FILL, default all ones (WIDTH bits), giving the value of vacated and reset entries.
REQ-004 The module SHALL have port clk, input, 1 bit, clock; all state updates on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit, synchronous, active-high reset.
REQ-006 The module SHALL have port push, input, 1 bit, shift toward bottom and insert d at top.
REQ-007 The module SHALL have port pop, input, 1 bit, shift toward top and discard top.
REQ-008 The module SHALL have port clr_err, input, 1 bit, clear sticky error flags.
REQ-009 The module SHALL have port d, input, WIDTH bits, data to insert.
REQ-010 The module SHALL have port top, output, WIDTH bits, equal to entry 0.
REQ-011 The module SHALL have port q_packed, output, DEPTH*WIDTH bits, with entry i at bits [WIDTH*i +: WIDTH] and entry 0 as top.
REQ-012 The module SHALL have port count, output, $clog2(DEPTH+1) bits, number of valid entries.
REQ-013 The module SHALL have port empty, output, 1 bit, high when count == 0.
REQ-014 The module SHALL have port full, output, 1 bit, high when count == DEPTH.
REQ-015 The module SHALL have port overflow, output, 1 bit, sticky flag for a push while full.
REQ-016 The module SHALL have port underflow, output, 1 bit, sticky flag for a pop while empty.

Function
REQ-017 Entries, count and error flags SHALL be registers; top, q_packed, empty and full SHALL be decoded from them combinationally, so every update is visible the cycle after the edge (latency 1).
REQ-018 On push only: entry 0 SHALL take d, and entry i SHALL take entry i-1 for 1 <= i < DEPTH; count SHALL increment.
REQ-019 On push only while full: the bottom entry SHALL be discarded, the shift SHALL still occur, count SHALL stay DEPTH, and overflow SHALL set.
REQ-020 On pop only with count > 0: entry i SHALL take entry i+1 for i < DEPTH-1, entry DEPTH-1 SHALL take FILL, and count SHALL decrement.
REQ-021 On pop only while empty: entries and count SHALL remain unchanged, and underflow SHALL set.
REQ-022 On push and pop together with count > 0: entry 0 SHALL take d (replace top), other entries and count SHALL remain unchanged, and no flag SHALL change.
REQ-023 On push and pop together while empty: the behaviour SHALL equal push only (count becomes 1), and underflow SHALL NOT set.
REQ-024 With neither push nor pop asserted, all entries and count SHALL hold.
REQ-025 clr_err SHALL clear overflow and underflow on the next edge, but an error event in the same cycle SHALL take priority and leave its flag set.
REQ-026 clr_err SHALL NOT affect entries or count.
REQ-027 count SHALL never exceed DEPTH nor wrap below 0.

Reset
REQ-028 When rst is high at an edge, all entries SHALL take FILL, count SHALL be 0, and overflow and underflow SHALL be 0, regardless of push, pop or clr_err.
REQ-029 After reset, outputs SHALL read: top = FILL, q_packed all FILL, empty = 1, full = 0.
REQ-030 Reset asserted mid-sequence SHALL abandon any in-progress fill level, with no residual state.

Verification
REQ-031 (DEPTH=4, WIDTH=8) Reset, then push 0x11, 0x22, 0x33, 0x44 on successive cycles -> q_packed = 0x11223344 (entry 3..0), count = 4, full = 1.
REQ-032 From REQ-031, push 0x55 -> q_packed = 0x22334455, count = 4, overflow = 1, which persists through 3 idle cycles.
REQ-033 From REQ-032, pop four times -> top sequence 0x44, 0x33, 0x22, then FILL; count = 0, empty = 1; a fifth pop -> underflow = 1, data unchanged.
REQ-034 Push 0xA0, then push and pop together with d = 0xB0 -> top = 0xB0, count = 1; push and pop together while empty with d = 0xC0 -> top = 0xC0, count = 1, underflow = 0.
REQ-035 With underflow = 1, assert clr_err together with a pop on empty -> underflow stays 1; then clr_err alone -> underflow = 0.
REQ-036 With count = 3, assert rst together with push -> count = 0, all entries = 0xFF, flags = 0.

Source files
------------

// File: rtl/bidir_shift_stack.sv
// Bidirectional shift stack: push shifts toward the bottom and inserts at the top,
// pop shifts toward the top; sticky overflow/underflow flags with clear.
module bidir_shift_stack #(
    parameter int               DEPTH = 8,
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] FILL  = {WIDTH{1'b1}}
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         clr_err,
    input  logic [WIDTH-1:0]             d,
    output logic [WIDTH-1:0]             top,
    output logic [DEPTH*WIDTH-1:0]       q_packed,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int             CW      = $clog2(DEPTH+1);
    localparam logic [CW-1:0]  ZERO_C  = CW'(0);
    localparam logic [CW-1:0]  ONE_C   = CW'(1);
    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0] mem_s [DEPTH];
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_s;
    logic             overflow_r;
    logic             overflow_s;
    logic             underflow_r;
    logic             underflow_s;
    logic             ovf_evt_s;
    logic             unf_evt_s;
    logic             is_empty_s;
    logic             is_full_s;

    assign is_empty_s = (count_r == ZERO_C);
    assign is_full_s  = (count_r == DEPTH_C);

    // Next-state decode for entries, fill level and sticky error flags.
    always_comb begin
        mem_s     = mem_r;
        count_s   = count_r;
        ovf_evt_s = 1'b0;
        unf_evt_s = 1'b0;
        case ({push, pop})
            2'b10: begin
                mem_s[0] = d;
                for (int i = 1; i < DEPTH; i++) begin
                    mem_s[i] = mem_r[i-1];
                end
                if (is_full_s) begin
                    ovf_evt_s = 1'b1;
                end else begin
                    count_s = count_r + ONE_C;
                end
            end
            2'b01: begin
                if (is_empty_s) begin
                    unf_evt_s = 1'b1;
                end else begin
                    for (int i = 0; i < DEPTH-1; i++) begin
                        mem_s[i] = mem_r[i+1];
                    end
                    mem_s[DEPTH-1] = FILL;
                    count_s        = count_r - ONE_C;
                end
            end
            2'b11: begin
                // On empty this degenerates to a plain push; otherwise top is replaced.
                if (is_empty_s) begin
                    mem_s[0] = d;
                    for (int i = 1; i < DEPTH; i++) begin
                        mem_s[i] = mem_r[i-1];
                    end
                    count_s = ONE_C;
                end else begin
                    mem_s[0] = d;
                end
            end
            default: begin
                count_s = count_r;
            end
        endcase
        overflow_s  = ovf_evt_s | (overflow_r  & ~clr_err);
        underflow_s = unf_evt_s | (underflow_r & ~clr_err);
    end

    // State registers with synchronous reset to the fill value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= FILL;
            end
            count_r     <= ZERO_C;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            mem_r       <= mem_s;
            count_r     <= count_s;
            overflow_r  <= overflow_s;
            underflow_r <= underflow_s;
        end
    end

    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : g_pack
            assign q_packed[WIDTH*g +: WIDTH] = mem_r[g];
        end
    endgenerate

    assign top       = mem_r[0];
    assign count     = count_r;
    assign empty     = is_empty_s;
    assign full      = is_full_s;
    assign overflow  = overflow_r;
    assign underflow = underflow_r;

endmodule

// File: tb/tb_bidir_shift_stack.sv
// Directed + short random bench for bidir_shift_stack (DEPTH=4, WIDTH=8) using a
// reference model whose expectations pass through a scoreboard queue.
module tb_bidir_shift_stack;

    localparam int DEPTH = 4;
    localparam int WIDTH = 8;

    logic        clk;
    logic        rst;
    logic        push;
    logic        pop;
    logic        clr_err;
    logic [7:0]  d;
    logic [7:0]  top;
    logic [31:0] q_packed;
    logic [2:0]  count;
    logic        empty;
    logic        full;
    logic        overflow;
    logic        underflow;

    typedef struct packed {
        logic [31:0] q;
        logic [2:0]  cnt;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t exp_q[$];

    logic [7:0] m [4];
    int         m_cnt;
    logic       m_ovf;
    logic       m_unf;

    int n_checks = 0;
    int n_fail   = 0;

    bidir_shift_stack #(.DEPTH(DEPTH), .WIDTH(WIDTH), .FILL(8'hFF)) dut (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .clr_err(clr_err), .d(d),
        .top(top), .q_packed(q_packed), .count(count), .empty(empty), .full(full),
        .overflow(overflow), .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: list-style stack, entry 0 is top.
    task automatic model(input logic r, input logic pu, input logic po, input logic c, input logic [7:0] dv);
        logic eo;
        logic eu;
        if (r) begin
            for (int i = 0; i < 4; i++) m[i] = 8'hFF;
            m_cnt = 0;
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            eo = pu && !po && (m_cnt == 4);
            eu = po && !pu && (m_cnt == 0);
            if (pu && (!po || m_cnt == 0)) begin
                m[3] = m[2]; m[2] = m[1]; m[1] = m[0]; m[0] = dv;
                if (m_cnt < 4) m_cnt++;
            end else if (pu && po) begin
                m[0] = dv;
            end else if (po && m_cnt > 0) begin
                m[0] = m[1]; m[1] = m[2]; m[2] = m[3]; m[3] = 8'hFF;
                m_cnt--;
            end
            m_ovf = eo | (m_ovf & !c);
            m_unf = eu | (m_unf & !c);
        end
    endtask

    task automatic step(input logic r, input logic pu, input logic po, input logic c, input logic [7:0] dv);
        exp_t e;
        exp_t got;
        model(r, pu, po, c, dv);
        e.q   = {m[3], m[2], m[1], m[0]};
        e.cnt = 3'(m_cnt);
        e.ovf = m_ovf;
        e.unf = m_unf;
        exp_q.push_back(e);
        rst = r; push = pu; pop = po; clr_err = c; d = dv;
        @(posedge clk);
        #1;
        rst = 1'b0; push = 1'b0; pop = 1'b0; clr_err = 1'b0;
        got = exp_q.pop_front();
        check("q_packed",  q_packed,         got.q);
        check("top",       {24'h0, top},     {24'h0, got.q[7:0]});
        check("count",     {29'h0, count},   {29'h0, got.cnt});
        check("empty",     {31'h0, empty},   {31'h0, (got.cnt == 3'd0)});
        check("full",      {31'h0, full},    {31'h0, (got.cnt == 3'd4)});
        check("overflow",  {31'h0, overflow},  {31'h0, got.ovf});
        check("underflow", {31'h0, underflow}, {31'h0, got.unf});
    endtask

    initial begin
        rst = 1'b1; push = 1'b0; pop = 1'b0; clr_err = 1'b0; d = 8'h00;
        for (int i = 0; i < 4; i++) m[i] = 8'h00;
        m_cnt = 0; m_ovf = 1'b0; m_unf = 1'b0;
        @(posedge clk);
        #1;

        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        check("rst_top",   {24'h0, top}, 32'h0000_00FF);
        check("rst_q",     q_packed,     32'hFFFF_FFFF);
        check("rst_empty", {31'h0, empty}, 32'h1);

        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h11);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h22);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h33);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h44);
        check("fill_q",    q_packed, 32'h1122_3344);
        check("fill_cnt",  {29'h0, count}, 32'h4);
        check("fill_full", {31'h0, full},  32'h1);

        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h55);
        check("ovf_q",   q_packed, 32'h2233_4455);
        check("ovf_cnt", {29'h0, count}, 32'h4);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        check("ovf_sticky", {31'h0, overflow}, 32'h1);

        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        check("pop1_top", {24'h0, top}, 32'h44);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        check("pop2_top", {24'h0, top}, 32'h33);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        check("pop3_top", {24'h0, top}, 32'h22);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        check("pop4_top",   {24'h0, top},  32'hFF);
        check("pop4_empty", {31'h0, empty}, 32'h1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        check("unf_set", {31'h0, underflow}, 32'h1);
        check("unf_q",   q_packed, 32'hFFFF_FFFF);

        // Error event wins over clear in the same cycle; the idle flag is cleared.
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        check("clr_pop_unf", {31'h0, underflow}, 32'h1);
        check("clr_pop_ovf", {31'h0, overflow},  32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        check("clr_unf", {31'h0, underflow}, 32'h0);

        step(1'b0, 1'b1, 1'b0, 1'b0, 8'hA0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'hB0);
        check("pp_top", {24'h0, top}, 32'hB0);
        check("pp_cnt", {29'h0, count}, 32'h1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'hC0);
        check("ppe_top", {24'h0, top}, 32'hC0);
        check("ppe_cnt", {29'h0, count}, 32'h1);
        check("ppe_unf", {31'h0, underflow}, 32'h0);

        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h01);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h02);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h03);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'hD0);
        check("ppf_q",   q_packed, 32'hC001_02D0);
        check("ppf_ovf", {31'h0, overflow}, 32'h0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'hE0);
        check("clr_push_ovf", {31'h0, overflow}, 32'h1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);

        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h77);
        check("rstp_cnt", {29'h0, count}, 32'h0);
        check("rstp_q",   q_packed, 32'hFFFF_FFFF);
        check("rstp_ovf", {31'h0, overflow}, 32'h0);

        for (int i = 0; i < 60; i++) begin
            step(($urandom_range(0, 19) == 0), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 5) == 0), 8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
